// File: rtl/alu_pkg.sv
// Shared op codes, FSM state encoding and signedness helpers for the alu_pipe slice.
// M-extension items are only referenced when ALU_MULDIV_EN is defined.
package alu_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00000;
   localparam logic [4:0] OP_SUB  = 5'b01000;
   localparam logic [4:0] OP_SLL  = 5'b00001;
   localparam logic [4:0] OP_SLT  = 5'b00010;
   localparam logic [4:0] OP_SLTU = 5'b00011;
   localparam logic [4:0] OP_XOR  = 5'b00100;
   localparam logic [4:0] OP_SRL  = 5'b00101;
   localparam logic [4:0] OP_SRA  = 5'b01101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_AND  = 5'b00111;

   localparam logic [2:0] M_MUL    = 3'd0;
   localparam logic [2:0] M_MULH   = 3'd1;
   localparam logic [2:0] M_MULHSU = 3'd2;
   localparam logic [2:0] M_MULHU  = 3'd3;
   localparam logic [2:0] M_DIV    = 3'd4;
   localparam logic [2:0] M_DIVU   = 3'd5;
   localparam logic [2:0] M_REM    = 3'd6;
   localparam logic [2:0] M_REMU   = 3'd7;

   // Divide by zero: quotient is all-ones, remainder is the dividend.
   localparam logic DIVZ_QUOT_FILL = 1'b1;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } alu_state_e;

   function automatic logic m_signed_a(input logic [2:0] f);
      return (f == M_MULH) || (f == M_MULHSU) || (f == M_DIV) || (f == M_REM);
   endfunction

   function automatic logic m_signed_b(input logic [2:0] f);
      return (f == M_MULH) || (f == M_DIV) || (f == M_REM);
   endfunction

endpackage

// File: rtl/alu_pipe_if.sv
// Valid/ready operand and result bus of alu_pipe; master drives ops and consumes results.
interface alu_pipe_if #(parameter int unsigned XLEN = 32);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      alu_op;
   logic [XLEN-1:0] operand1;
   logic [XLEN-1:0] operand2;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] alu_out;
   logic            out_err;

   modport master (
      output in_valid, alu_op, operand1, operand2, out_ready,
      input  in_ready, out_valid, alu_out, out_err
   );

   modport slave (
      input  in_valid, alu_op, operand1, operand2, out_ready,
      output in_ready, out_valid, alu_out, out_err
   );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative RV M-extension unit (built only with ALU_MULDIV_EN): radix-2 shift-add
// multiply / restoring divide on magnitudes, exactly XLEN iterations, sign fixed at the end.
module alu_muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            kill,
   input  logic            start,
   input  logic [2:0]      func,
   input  logic [XLEN-1:0] op_a,
   input  logic [XLEN-1:0] op_b,
   output logic            done,
   output logic [XLEN-1:0] result
);
   localparam int unsigned CNT_W = $clog2(XLEN);

   logic              run;
   logic [CNT_W-1:0]  cnt;
   logic [XLEN-1:0]   hi, lo, mc, a_raw, hi_n, lo_n;
   logic [2:0]        func_q;
   logic              neg_q, neg_r, b_zero;
   logic              a_neg, b_neg;
   logic [XLEN-1:0]   mag_a, mag_b, quo, rem;
   logic [XLEN:0]     sum, sh, diff;
   logic [2*XLEN-1:0] prod;

   always_comb begin
      a_neg = m_signed_a(func) && op_a[XLEN-1];
      b_neg = m_signed_b(func) && op_b[XLEN-1];
      mag_a = a_neg ? -op_a : op_a;
      mag_b = b_neg ? -op_b : op_b;
   end

   // hi:lo is the product for multiply and remainder:quotient for divide.
   always_comb begin
      sum  = {1'b0, hi} + (lo[0] ? {1'b0, mc} : '0);
      sh   = {hi, lo[XLEN-1]};
      diff = sh - {1'b0, mc};
      if (func_q[2]) begin
         hi_n = diff[XLEN] ? sh[XLEN-1:0] : diff[XLEN-1:0];
         lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
      end else begin
         hi_n = sum[XLEN:1];
         lo_n = {sum[0], lo[XLEN-1:1]};
      end
   end

   assign done = run && (cnt == CNT_W'(XLEN - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run    <= 1'b0;
         cnt    <= '0;
         hi     <= '0;
         lo     <= '0;
         mc     <= '0;
         a_raw  <= '0;
         func_q <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
      end else if (kill) begin
         run <= 1'b0;
      end else if (start) begin
         run    <= 1'b1;
         cnt    <= '0;
         hi     <= '0;
         lo     <= mag_a;
         mc     <= mag_b;
         a_raw  <= op_a;
         func_q <= func;
         neg_q  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         b_zero <= (op_b == '0);
      end else if (run) begin
         hi  <= hi_n;
         lo  <= lo_n;
         cnt <= cnt + 1'b1;
         if (done) run <= 1'b0;
      end
   end

   // Result is taken from the final iteration's next-state so it lands on the done edge.
   always_comb begin
      prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
      quo  = neg_q ? -lo_n : lo_n;
      rem  = neg_r ? -hi_n : hi_n;
      case (func_q)
         M_MUL:                     result = prod[XLEN-1:0];
         M_MULH, M_MULHSU, M_MULHU: result = prod[2*XLEN-1:XLEN];
         M_DIV, M_DIVU:             result = b_zero ? {XLEN{DIVZ_QUOT_FILL}} : quo;
         default:                   result = b_zero ? a_raw : rem;
      endcase
   end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked EX-stage ALU: registered RV base ops in one cycle; with ALU_MULDIV_EN defined,
// M-extension ops run XLEN+1 cycles in alu_muldiv_iter while upstream is stalled.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       flush,
   alu_pipe_if.slave  bus
);
   localparam int unsigned SHAMT_W = $clog2(XLEN);

   alu_state_e         state_q, state_d;
   logic               ready_en, busy, accept, out_fire, m_sel, m_done;
   logic [XLEN-1:0]    a, b, base_res, m_result, alu_out_q;
   logic [SHAMT_W-1:0] shamt;
   logic               base_err, out_valid_q, out_err_q;

   assign a     = bus.operand1;
   assign b     = bus.operand2;
   assign shamt = b[SHAMT_W-1:0];

   always_comb begin
      base_res = '0;
      base_err = 1'b0;
      case (bus.alu_op)
         OP_ADD:  base_res = a + b;
         OP_SUB:  base_res = a - b;
         OP_SLL:  base_res = a << shamt;
         OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
         OP_SLTU: base_res = {{(XLEN-1){1'b0}}, a < b};
         OP_XOR:  base_res = a ^ b;
         OP_SRL:  base_res = a >> shamt;
         OP_SRA:  base_res = $unsigned($signed(a) >>> shamt);
         OP_OR:   base_res = a | b;
         OP_AND:  base_res = a & b;
         default: base_err = 1'b1;
      endcase
   end

`ifdef ALU_MULDIV_EN
   assign m_sel = bus.alu_op[4] && !bus.alu_op[3];

   alu_muldiv_iter #(.XLEN(XLEN)) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .kill   (flush),
      .start  (accept && m_sel),
      .func   (bus.alu_op[2:0]),
      .op_a   (a),
      .op_b   (b),
      .done   (m_done),
      .result (m_result)
   );
`else
   assign m_sel    = 1'b0;
   assign m_done   = 1'b0;
   assign m_result = '0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ready_en <= 1'b0;
      else        ready_en <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    if (accept && m_sel) state_d = BUSY;
            BUSY:    if (m_done) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      busy         = (state_q == BUSY);
      bus.in_ready = ready_en && !busy && (!out_valid_q || bus.out_ready);
   end

   assign accept   = bus.in_valid && bus.in_ready && !flush;
   assign out_fire = out_valid_q && bus.out_ready;

   // Accepting an M op falls through to the out_fire branch, retiring any held result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         alu_out_q   <= '0;
      end else if (flush) begin
         out_valid_q <= 1'b0;
         out_err_q   <= 1'b0;
         alu_out_q   <= '0;
      end else if (m_done) begin
         out_valid_q <= 1'b1;
         out_err_q   <= 1'b0;
         alu_out_q   <= m_result;
      end else if (accept && !m_sel) begin
         out_valid_q <= 1'b1;
         out_err_q   <= base_err;
         alu_out_q   <= base_res;
      end else if (out_fire) begin
         out_valid_q <= 1'b0;
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_err   = out_err_q;
   assign bus.alu_out   = alu_out_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (XLEN=32): base-op table, backpressure, flush, reset,
// illegal ops, and M-extension latency/values when ALU_MULDIV_EN is defined.
module tb_alu_pipe;
   import alu_pkg::*;

   localparam int unsigned XLEN = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic flush = 1'b0;

   alu_pipe_if #(.XLEN(XLEN)) bus ();

   alu_pipe #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      string       name;
      logic [4:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      logic        err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input string name, input logic [4:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp, input logic err);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.exp = exp; v.err = err;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
      bus.in_valid = 1'b1;
      bus.alu_op   = op;
      bus.operand1 = a;
      bus.operand2 = b;
   endtask

`ifdef ALU_MULDIV_EN
   task automatic run_m(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
      int cycles;
      @(negedge clk);
      drive(op, a, b);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      cycles = 1;
      while (!bus.out_valid && cycles < 100) begin
         @(posedge clk); #1;
         cycles++;
      end
      check({name, " latency"}, cycles, XLEN + 1);
      check({name, " value"}, bus.alu_out, exp);
      check({name, " err"}, bus.out_err, 1'b0);
   endtask
`endif

   initial begin
      bus.in_valid  = 1'b0;
      bus.alu_op    = '0;
      bus.operand1  = '0;
      bus.operand2  = '0;
      bus.out_ready = 1'b1;

      vecs.push_back(mk("ADD",        OP_ADD,  32'h5,        32'h3,        32'h8,        1'b0));
      vecs.push_back(mk("ADD wrap",   OP_ADD,  32'hFFFFFFFF, 32'h1,        32'h0,        1'b0));
      vecs.push_back(mk("SUB 0-1",    OP_SUB,  32'h0,        32'h1,        32'hFFFFFFFF, 1'b0));
      vecs.push_back(mk("SUB",        OP_SUB,  32'hA,        32'h3,        32'h7,        1'b0));
      vecs.push_back(mk("SLL",        OP_SLL,  32'h1,        32'h24,       32'h10,       1'b0));
      vecs.push_back(mk("SLT",        OP_SLT,  32'hFFFFFFFF, 32'h1,        32'h1,        1'b0));
      vecs.push_back(mk("SLTU",       OP_SLTU, 32'hFFFFFFFF, 32'h1,        32'h0,        1'b0));
      vecs.push_back(mk("SLT rev",    OP_SLT,  32'h1,        32'hFFFFFFFF, 32'h0,        1'b0));
      vecs.push_back(mk("XOR",        OP_XOR,  32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0));
      vecs.push_back(mk("SRL 31",     OP_SRL,  32'h80000000, 32'h3F,       32'h1,        1'b0));
      vecs.push_back(mk("SRA 31",     OP_SRA,  32'h80000000, 32'h3F,       32'hFFFFFFFF, 1'b0));
      vecs.push_back(mk("SRA pos",    OP_SRA,  32'h40000000, 32'h4,        32'h04000000, 1'b0));
      vecs.push_back(mk("OR",         OP_OR,   32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0));
      vecs.push_back(mk("AND",        OP_AND,  32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0));
      vecs.push_back(mk("ILL 01111",  5'b01111, 32'h5,       32'h3,        32'h0,        1'b1));
      vecs.push_back(mk("ILL 11000",  5'b11000, 32'h5,       32'h3,        32'h0,        1'b1));
`ifndef ALU_MULDIV_EN
      vecs.push_back(mk("ILL 10000",  5'b10000, 32'h5,       32'h3,        32'h0,        1'b1));
`endif

      // Reset state
      #3;
      check("reset out_valid", bus.out_valid, 1'b0);
      check("reset alu_out",   bus.alu_out,   32'h0);
      check("reset in_ready",  bus.in_ready,  1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 check("in_ready before first edge", bus.in_ready, 1'b0);
      @(posedge clk); #1;
      check("in_ready after release", bus.in_ready, 1'b1);

      // Base table, back-to-back at one op per cycle
      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].op, vecs[i].a, vecs[i].b);
         @(posedge clk); #1;
         check({vecs[i].name, " valid"}, bus.out_valid, 1'b1);
         check({vecs[i].name, " out"},   bus.alu_out,   vecs[i].exp);
         check({vecs[i].name, " err"},   bus.out_err,   vecs[i].err);
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("drain valid", bus.out_valid, 1'b0);

      // Backpressure: three ADDs with the consumer stalled for four cycles
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(OP_ADD, 32'h1, 32'h1);
      @(posedge clk); #1;
      check("bp first valid", bus.out_valid, 1'b1);
      check("bp first out",   bus.alu_out,   32'h2);
      @(negedge clk);
      drive(OP_ADD, 32'h2, 32'h2);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check("bp stall in_ready", bus.in_ready,  1'b0);
         check("bp stall hold",     bus.alu_out,   32'h2);
         check("bp stall valid",    bus.out_valid, 1'b1);
      end
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1 check("bp release in_ready", bus.in_ready, 1'b1);
      @(posedge clk); #1;
      check("bp second out", bus.alu_out, 32'h4);
      @(negedge clk);
      drive(OP_ADD, 32'h3, 32'h3);
      @(posedge clk); #1;
      check("bp third out", bus.alu_out, 32'h6);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
      check("bp no duplicate", bus.out_valid, 1'b0);

      // Flush a held illegal result with a concurrent in_valid
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(5'b01111, 32'h9, 32'h9);
      @(posedge clk); #1;
      check("fl held err", bus.out_err, 1'b1);
      @(negedge clk);
      flush = 1'b1;
      drive(OP_ADD, 32'h1, 32'h1);
      @(posedge clk); #1;
      check("fl valid cleared", bus.out_valid, 1'b0);
      check("fl err cleared",   bus.out_err,   1'b0);
      @(negedge clk);
      flush = 1'b0;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("fl op not accepted", bus.out_valid, 1'b0);

`ifdef ALU_MULDIV_EN
      begin
         bit seen;
         @(negedge clk);
         drive(5'b10100, 32'd100, 32'd7);
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
         repeat (8) @(posedge clk);
         @(negedge clk);
         flush = 1'b1;
         @(posedge clk); #1;
         flush = 1'b0;
         seen = 1'b0;
         repeat (40) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1'b1;
         end
         check("div flush no result", seen, 1'b0);
      end
`endif

      @(negedge clk);
      drive(OP_ADD, 32'h2, 32'h3);
      @(posedge clk); #1;
      check("post-flush ADD valid", bus.out_valid, 1'b1);
      check("post-flush ADD out",   bus.alu_out,   32'h5);
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(posedge clk); #1;

`ifdef ALU_MULDIV_EN
      run_m("MULH min*min", 5'b10001, 32'h80000000, 32'h80000000, 32'h40000000);
      run_m("DIV ovf",      5'b10100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      run_m("REM ovf",      5'b10110, 32'h80000000, 32'hFFFFFFFF, 32'h0);
      run_m("REMU by 0",    5'b10111, 32'h7,        32'h0,        32'h7);
      run_m("DIV by 0",     5'b10100, 32'h5,        32'h0,        32'hFFFFFFFF);
      run_m("MUL neg",      5'b10000, 32'h7,        32'hFFFFFFFD, 32'hFFFFFFEB);
      run_m("REM neg",      5'b10110, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF);
      run_m("DIVU",         5'b10101, 32'd100,      32'd7,        32'd14);
      run_m("MULHU",        5'b10011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      run_m("MULHSU",       5'b10010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
`endif

      // Asynchronous reset with a held result
      @(negedge clk);
      bus.out_ready = 1'b0;
      drive(OP_ADD, 32'h7, 32'h8);
      @(posedge clk); #1;
      check("pre-reset out", bus.alu_out, 32'hF);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("async reset valid",    bus.out_valid, 1'b0);
      check("async reset out",      bus.alu_out,   32'h0);
      check("async reset in_ready", bus.in_ready,  1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      check("re-release in_ready", bus.in_ready, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected $finish");
      $fatal(1, "timeout");
   end

endmodule
